stage3_hazard_unit: RTL
=======================

# stage3_hazard_unit

Stall/flush controller for the three-stage pipeline. Complements the execute-stage forwarding unit, which forwards M-stage ALU results but deliberately excludes loads. This block handles the remaining cases:
- holds fetch and execute when an E-stage instruction depends on a load still in M;
- inserts a bubble into M once that load retires;
- sequences the flush after a branch mispredict, discarding stale instruction-memory responses.

It also keeps a saturating load-use stall counter for performance analysis.

## Interface
Parameters:
- CNT_W, 16, width of the load-use stall counter

Ports:
- CLK  in  1  pipeline clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- rs1_e  in  5  source register 1 of the E-stage instruction
- rs2_e  in  5  source register 2 of the E-stage instruction
- ex_valid  in  1  E stage holds a valid instruction
- rd_m  in  5  destination register of the M-stage instruction
- reg_write_m  in  1  M-stage instruction writes rd_m
- load_m  in  1  M-stage instruction is a load
- mem_valid  in  1  M stage holds a valid instruction
- dmem_busy  in  1  data memory has not completed the M-stage access this cycle
- imem_busy  in  1  instruction fetch outstanding, response not yet returned
- mispredict_m  in  1  M-stage control transfer resolved as mispredicted (one-cycle pulse)
- cnt_clr  in  1  synchronous clear of lu_count
- stall_f  out  1  hold PC and fetch register
- stall_e  out  1  hold E-stage register
- bubble_m  out  1  load NOP into M at next edge instead of E contents
- flush_e  out  1  kill E-stage register contents at next edge
- hazard_active  out  1  state is not RUN
- lu_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- lu_hit = ex_valid & mem_valid & load_m & reg_write_m & (rd_m != 0) & ((rs1_e == rd_m) | (rs2_e == rd_m)).
- The register file is written at the edge ending the cycle in which the load completes (dmem_busy=0). E reads the correct value on the following cycle.
- FSM states: RUN, LU_WAIT, FLUSH_WAIT.
- RUN, mispredict_m=1:
  - flush_e=1, stall_f=stall_e=0.
  - Next state is FLUSH_WAIT if imem_busy=1, else RUN.
  - Mispredict takes priority over lu_hit, because the dependent instruction is being killed.
- RUN, lu_hit=1, dmem_busy=0: stall_f=stall_e=1, bubble_m=1, stay RUN.
- RUN, lu_hit=1, dmem_busy=1: stall_f=stall_e=1, bubble_m=0, go to LU_WAIT.
- RUN, otherwise: all control outputs 0.
- LU_WAIT:
  - stall_f=stall_e=1.
  - bubble_m equals !dmem_busy.
  - When dmem_busy=0, return to RUN.
  - mispredict_m cannot occur in this state (M holds a load). If it is asserted, it is ignored and an assertion fires.
- FLUSH_WAIT:
  - flush_e=1 and stall_f=0 every cycle.
  - The stale fetch response is dropped into the flushed E register.
  - When imem_busy=0, flush_e=1 for that final cycle, then go to RUN.
  - lu_hit is ignored in this state.
- hazard_active = (state != RUN).
- lu_count:
  - increments by 1 on every cycle where stall_e=1 due to a load-use hazard (RUN with lu_hit, or LU_WAIT);
  - saturates at 2^CNT_W-1 and does not wrap;
  - cnt_clr has priority over increment; value is 0 on the edge after cnt_clr.

## Timing
- Reset (nRST=0, asynchronous): state=RUN, lu_count=0.
- While in reset, all control outputs are 0, since in RUN they are gated by ex_valid/mem_valid/mispredict_m.
- Reset mid-stall (in LU_WAIT or FLUSH_WAIT) returns to RUN immediately, with no pending stall or flush carried over.
- Control outputs are combinational from state and current inputs and are valid in the same cycle; only state and lu_count are registered.
- Load-use stall length = (number of dmem_busy cycles) + 1. Minimum is 1 cycle when the load completes immediately.
- Flush length = 1 cycle if imem_busy=0 at the mispredict, else (remaining busy cycles) + 1.
- stall_e=1 always implies stall_f=1. bubble_m=1 is never asserted together with flush_e=1.

## Test plan
- No hazard: load_m=1, rd_m=5, rs1_e=6, rs2_e=7, dmem_busy=0 -> stall_f/stall_e/bubble_m all 0; lu_count stays 0.
- Single-cycle load-use: rd_m=5, rs2_e=5, load_m=1, dmem_busy=0 -> one cycle of stall_e=stall_f=bubble_m=1; state stays RUN; lu_count=1.
- Multi-cycle load-use: rd_m=3, rs1_e=3, dmem_busy high for 3 cycles -> 4 cycles of stall_e; bubble_m only on the 4th; hazard_active high for cycles 2-4; lu_count=4.
- x0 destination: rd_m=0, rs1_e=0, load_m=1 -> no stall.
- Mispredict with imem_busy high 2 cycles -> flush_e=1 for 3 cycles; stall_f=0 throughout; state back to RUN; a lu_hit present in the same cycle produces no stall.
- Counter saturation and reset: CNT_W=2 with 5 stall cycles -> lu_count holds 3. cnt_clr plus stall in the same cycle -> 0. nRST asserted during LU_WAIT -> state RUN and lu_count=0 immediately.

Source files
------------

// File: rtl/stage3_hazard_unit.sv
// stage3_hazard_unit
// Stall/flush controller for the three-stage pipeline.
// - Holds fetch and execute while an E-stage instruction depends on a load
//   that is still in M.
// - Inserts a bubble into M once that load retires.
// - Runs the flush sequence after a branch mispredict, soaking up stale
//   instruction-memory responses.
// - Keeps a saturating count of load-use stall cycles.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   rs1_e, rs2_e         E-stage source registers
//   ex_valid             E stage holds a valid instruction
//   rd_m, reg_write_m    M-stage destination register and its write enable
//   load_m, mem_valid    M-stage instruction is a load / is valid
//   dmem_busy            data memory has not completed the M access
//   imem_busy            instruction fetch response still outstanding
//   mispredict_m         one-cycle mispredict pulse from M
//   cnt_clr              synchronous clear of lu_count
//   stall_f, stall_e     hold fetch / E-stage registers
//   bubble_m             load a NOP into M at the next edge
//   flush_e              kill E-stage contents at the next edge
//   hazard_active        controller is not in RUN
//   lu_count             saturating load-use stall cycle count
module stage3_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic             ex_valid,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic             load_m,
  input  logic             mem_valid,
  input  logic             dmem_busy,
  input  logic             imem_busy,
  input  logic             mispredict_m,
  input  logic             cnt_clr,
  output logic             stall_f,
  output logic             stall_e,
  output logic             bubble_m,
  output logic             flush_e,
  output logic             hazard_active,
  output logic [CNT_W-1:0] lu_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_WAIT    = 2'd1,
    FLUSH_WAIT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             lu_hit_s;
  logic             lu_inc_s;
  logic [CNT_W-1:0] lu_count_r;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Load-use detection: x0 is never a real dependency.
  always_comb begin
    lu_hit_s = ex_valid & mem_valid & load_m & reg_write_m &
               (rd_m != 5'd0) & ((rs1_e == rd_m) | (rs2_e == rd_m));
  end

  // Next-state and control-output decode.
  always_comb begin
    state_nxt_s   = state_r;
    stall_f       = 1'b0;
    stall_e       = 1'b0;
    bubble_m      = 1'b0;
    flush_e       = 1'b0;
    lu_inc_s      = 1'b0;
    hazard_active = (state_r != RUN);
    case (state_r)
      RUN: begin
        // The dependent instruction is being killed, so the mispredict wins.
        if (mispredict_m) begin
          flush_e = 1'b1;
          if (imem_busy) begin
            state_nxt_s = FLUSH_WAIT;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (lu_hit_s) begin
          stall_f  = 1'b1;
          stall_e  = 1'b1;
          lu_inc_s = 1'b1;
          // Load finishing now: regfile written at this edge, so retire it.
          if (dmem_busy) begin
            bubble_m    = 1'b0;
            state_nxt_s = LU_WAIT;
          end else begin
            bubble_m    = 1'b1;
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      LU_WAIT: begin
        // A mispredict cannot legally appear here; it is ignored.
        stall_f  = 1'b1;
        stall_e  = 1'b1;
        lu_inc_s = 1'b1;
        bubble_m = ~dmem_busy;
        if (dmem_busy) begin
          state_nxt_s = LU_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH_WAIT: begin
        // Stale fetch data lands in the flushed E register every cycle,
        // including the one where the response finally returns.
        flush_e = 1'b1;
        if (imem_busy) begin
          state_nxt_s = FLUSH_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Saturating load-use stall counter; clear beats increment.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lu_count_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      lu_count_r <= {CNT_W{1'b0}};
    end else if (lu_inc_s && (lu_count_r != CNT_MAX)) begin
      lu_count_r <= lu_count_r + CNT_ONE;
    end else begin
      lu_count_r <= lu_count_r;
    end
  end

  assign lu_count = lu_count_r;

  stage3_hazard_unit_chk u_chk (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_lu_wait   (state_r == LU_WAIT),
    .mispredict_m (mispredict_m),
    .stall_f      (stall_f),
    .stall_e      (stall_e),
    .bubble_m     (bubble_m),
    .flush_e      (flush_e)
  );

endmodule

// Protocol and output-consistency properties for stage3_hazard_unit.
module stage3_hazard_unit_chk (
  input logic CLK,
  input logic nRST,
  input logic in_lu_wait,
  input logic mispredict_m,
  input logic stall_f,
  input logic stall_e,
  input logic bubble_m,
  input logic flush_e
);

  a_no_mispredict_in_lu_wait : assert property (
    @(posedge CLK) disable iff (!nRST) !(in_lu_wait && mispredict_m));

  a_stall_e_implies_stall_f : assert property (
    @(posedge CLK) disable iff (!nRST) (!stall_e || stall_f));

  a_bubble_excludes_flush : assert property (
    @(posedge CLK) disable iff (!nRST) !(bubble_m && flush_e));

endmodule
